// File: rtl/chip8_fb_arbiter.sv
// chip8_fb_arbiter: shares the single-port 2048x1 Chip8 framebuffer RAM
// between VGA scan-out (fixed phase-0 slots), the CPU draw/read port
// (req/ack) and the CLS clear-screen sequencer.
// Optional feature macro: CHIP8_FB_XOR_EN -- CPU writes become DRW-style
// XOR read-modify-writes that return the collision flag on cpu_rdata.
module chip8_fb_arbiter #(
  parameter int                ADDR_W    = 11,
  parameter logic [ADDR_W-1:0] FB_LAST   = 11'd2047,
  parameter logic              CLEAR_VAL = 1'b0
) (
  input  logic              clk50,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              vga_phase,
  input  logic              vga_active,
  output logic              vga_pixel,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_wdata,
  input  logic              mem_rdata
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CPU_ACK    = 3'd1,
    CLEAR      = 3'd2,
    CPU_RMW_RD = 3'd3,
    CPU_RMW_WR = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              tx_we;       // kind of the CPU access in flight
  logic              clr_pend;    // clear request seen while an RMW was in flight
  logic              vga_slot_d;  // previous cycle was a VGA slot
`ifdef CHIP8_FB_XOR_EN
  logic              old_val;     // pixel value read by the RMW, held across VGA slots
  logic              rmw_wr;
`endif

  logic vga_slot;
  logic free_slot;
  logic cpu_grant;
  logic clr_wr;

  assign vga_slot  = vga_active & ~vga_phase;
  assign free_slot = ~vga_slot;
  // A CPU grant is held off while the previous ack is still visible so a
  // CPU that drops cpu_req on seeing the ack is never granted twice.
  assign cpu_grant = (state == IDLE) & free_slot & cpu_req & ~cpu_ack
                   & ~clr_start & ~clr_pend;
  assign clr_wr    = (state == CLEAR) & free_slot;
`ifdef CHIP8_FB_XOR_EN
  assign rmw_wr    = (state == CPU_RMW_WR) & free_slot;
`endif

  // RAM port mux: VGA slot first, then clear, then the CPU, else idle.
  always_comb begin
    mem_addr  = {ADDR_W{1'b0}};
    mem_we    = 1'b0;
    mem_wdata = 1'b0;
    if (vga_slot) begin
      mem_addr = vga_addr;
    end else if (clr_wr) begin
      mem_addr  = clr_cnt;
      mem_we    = 1'b1;
      mem_wdata = CLEAR_VAL;
    end
`ifdef CHIP8_FB_XOR_EN
    else if (rmw_wr) begin
      mem_addr  = cpu_addr;
      mem_we    = 1'b1;
      mem_wdata = old_val ^ cpu_wdata;
    end else if (cpu_grant) begin
      // Reads and the read half of an RMW both start as a plain read.
      mem_addr = cpu_addr;
      mem_we   = 1'b0;
    end
`else
    else if (cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
`endif
    else begin
      mem_addr = {ADDR_W{1'b0}};
    end
  end

  // Scan-out pixel register: capture RAM data the cycle after a VGA slot.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      vga_slot_d <= 1'b0;
      vga_pixel  <= 1'b0;
    end else begin
      vga_slot_d <= vga_slot;
      if (vga_slot_d) begin
        vga_pixel <= mem_rdata;
      end else if (!vga_active) begin
        vga_pixel <= 1'b0;
      end else begin
        vga_pixel <= vga_pixel;
      end
    end
  end

  // Arbiter FSM: clear sequencer, CPU handshake and registered status.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      clr_cnt   <= {ADDR_W{1'b0}};
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      clr_pend  <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 1'b0;
      tx_we     <= 1'b0;
`ifdef CHIP8_FB_XOR_EN
      old_val   <= 1'b0;
`endif
    end else begin
      cpu_ack  <= 1'b0;
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start || clr_pend) begin
            state    <= CLEAR;
            clr_cnt  <= {ADDR_W{1'b0}};
            clr_busy <= 1'b1;
            clr_pend <= 1'b0;
          end else if (cpu_grant) begin
            tx_we <= cpu_we;
`ifdef CHIP8_FB_XOR_EN
            state <= cpu_we ? CPU_RMW_RD : CPU_ACK;
`else
            state <= CPU_ACK;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CPU_ACK: begin
          cpu_ack <= 1'b1;
`ifdef CHIP8_FB_XOR_EN
          cpu_rdata <= tx_we ? (old_val & cpu_wdata) : mem_rdata;
`else
          cpu_rdata <= tx_we ? 1'b0 : mem_rdata;
`endif
          if (clr_start || clr_pend) begin
            state    <= CLEAR;
            clr_cnt  <= {ADDR_W{1'b0}};
            clr_busy <= 1'b1;
            clr_pend <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          if (clr_wr) begin
            if (clr_cnt == FB_LAST) begin
              clr_busy <= 1'b0;
              clr_done <= 1'b1;
              state    <= IDLE;
            end else begin
              clr_cnt <= clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end else begin
            clr_cnt <= clr_cnt;
          end
        end
`ifdef CHIP8_FB_XOR_EN
        CPU_RMW_RD: begin
          old_val <= mem_rdata;
          state   <= CPU_RMW_WR;
          if (clr_start) begin
            clr_pend <= 1'b1;
          end else begin
            clr_pend <= clr_pend;
          end
        end
        CPU_RMW_WR: begin
          if (free_slot) begin
            state <= CPU_ACK;
          end else begin
            state <= CPU_RMW_WR;
          end
          if (clr_start) begin
            clr_pend <= 1'b1;
          end else begin
            clr_pend <= clr_pend;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_fb_arbiter.sv
// Self-checking bench for chip8_fb_arbiter: framebuffer RAM model, table of
// CPU transactions, directed clear/reset sequences and randomized traffic
// checked against a transaction-level shadow of the framebuffer.
module tb_chip8_fb_arbiter;

  localparam int AW   = 11;
  localparam int NPIX = 2048;
`ifdef CHIP8_FB_XOR_EN
  localparam bit XOR_MODE  = 1'b1;
  localparam int LAT_BOUND = 6;
`else
  localparam bit XOR_MODE  = 1'b0;
  localparam int LAT_BOUND = 3;
`endif

  logic          clk50 = 1'b0;
  logic          reset_n;
  logic [AW-1:0] vga_addr;
  logic          vga_phase;
  logic          vga_active;
  logic          vga_pixel;
  logic          cpu_req, cpu_we, cpu_wdata, cpu_ack, cpu_rdata;
  logic [AW-1:0] cpu_addr;
  logic          clr_start, clr_busy, clr_done;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_wdata, mem_rdata;

  always #10 clk50 = ~clk50;

  chip8_fb_arbiter dut (
    .clk50(clk50), .reset_n(reset_n),
    .vga_addr(vga_addr), .vga_phase(vga_phase), .vga_active(vga_active),
    .vga_pixel(vga_pixel),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic cb_pix(input int a);
    return 1'(a ^ (a >> 6));
  endfunction

  // Framebuffer RAM: synchronous read with one cycle of latency, bulk fill.
  logic ram [0:NPIX-1];
  logic fill_req = 1'b0;
  logic fill_cb  = 1'b0;
  always @(posedge clk50) begin
    if (fill_req) begin
      for (int i = 0; i < NPIX; i++) ram[i] <= fill_cb ? cb_pix(i) : 1'($urandom);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int   n_vec = 0, n_bad = 0, cyc = 0;
  logic shadow [0:NPIX-1];
  bit   p1_valid = 1'b0;
  logic p1_val = 1'b0;
  logic exp_pix = 1'b0;
  bit   cpu_pending = 1'b0;
  logic cpu_exp = 1'b0;
  int   cpu_wait = 0;
  int   last_ack_cyc = -1, last_done_cyc = -1;
  bit   clr_mon = 1'b0;
  int   clr_next = 0, done_cnt = 0;

  typedef struct {
    bit we;
    int addr;
    bit wdata;
    bit exp_plain;
    bit exp_xor;
  } cpu_vec_t;
  cpu_vec_t tbl [13];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cpu_issue(input bit we, input int a, input bit wd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = 11'(a); cpu_wdata = wd;
    cpu_pending = 1'b1; cpu_wait = 0;
    if (!we) begin
      cpu_exp = shadow[a];
    end else if (XOR_MODE) begin
      cpu_exp   = shadow[a] & wd;
      shadow[a] = shadow[a] ^ wd;
    end else begin
      cpu_exp   = 1'b0;
      shadow[a] = wd;
    end
  endtask

  // One clock: pre-edge checks of the RAM port, post-edge checks of outputs.
  task automatic step();
    bit slot;
    @(negedge clk50);
    slot = vga_active && !vga_phase;
    if (slot) chk("vga_slot_we", mem_we, 0);
    if (clr_mon && !slot) chk("clr_we", mem_we, clr_busy);
    if (clr_mon && mem_we) begin
      chk("clr_addr", mem_addr, clr_next);
      chk("clr_wdata", mem_wdata, 0);
      clr_next++;
    end
    if (cpu_pending && clr_busy) cpu_wait = 0;
    if (p1_valid) exp_pix = p1_val;
    else if (!vga_active) exp_pix = 1'b0;
    p1_valid = slot;
    p1_val   = ram[vga_addr];
    @(posedge clk50);
    #1;
    cyc++;
    chk("vga_pixel", vga_pixel, exp_pix);
    if (clr_done) begin
      done_cnt++;
      last_done_cyc = cyc;
      chk("busy_on_done", clr_busy, 0);
    end
    if (cpu_pending) begin
      cpu_wait++;
      if (cpu_ack) begin
        chk("cpu_rdata", cpu_rdata, cpu_exp);
        chk("cpu_latency_ok", int'(cpu_wait <= LAT_BOUND), 1);
        cpu_pending  = 1'b0;
        cpu_req      = 1'b0;
        last_ack_cyc = cyc;
      end
    end else begin
      chk("cpu_spurious_ack", cpu_ack, 0);
    end
  endtask

  task automatic tick(input bit act);
    vga_active = act;
    vga_phase  = ~vga_phase;
    vga_addr   = 11'($urandom);
    step();
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_vga_pixel"}, vga_pixel, 0);
    chk({pfx, "_cpu_ack"}, cpu_ack, 0);
    chk({pfx, "_cpu_rdata"}, cpu_rdata, 0);
    chk({pfx, "_clr_busy"}, clr_busy, 0);
    chk({pfx, "_clr_done"}, clr_done, 0);
    chk({pfx, "_mem_we"}, mem_we, 0);
  endtask

  initial begin
    int  cnt;
    bit  act;
    bit  restarted;
    reset_n = 1'b0; vga_addr = '0; vga_phase = 1'b0; vga_active = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 1'b0; clr_start = 1'b0;

    tbl[0]  = '{1'b1, 100,  1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 100,  1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 99,   1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 5,    1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 5,    1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 5,    1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2047, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2047, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 0,    1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 0,    1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 100,  1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 100,  1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 101,  1'b0, 1'b0, 1'b0};

    // Reset with random RAM contents.
    fill_req = 1'b1; fill_cb = 1'b0;
    @(posedge clk50); #1;
    fill_req = 1'b0;
    @(posedge clk50); #1;
    chk_reset("reset");
    reset_n = 1'b1;

    // Clear in blanking, CPU read raised together with clr_start, re-start ignored.
    clr_mon = 1'b1; clr_next = 0; done_cnt = 0; restarted = 1'b0;
    for (int i = 0; i < NPIX; i++) shadow[i] = 1'b0;
    clr_start = 1'b1;
    cpu_issue(1'b0, 7, 1'b0);
    tick(1'b0);
    clr_start = 1'b0;
    for (int k = 0; k < 5000 && done_cnt == 0; k++) begin
      if (clr_next == 1000 && !restarted) begin
        clr_start = 1'b1;
        restarted = 1'b1;
      end
      tick(1'b0);
      clr_start = 1'b0;
    end
    for (int k = 0; k < 10 && cpu_pending; k++) tick(1'b0);
    chk("cpu_done_after_clear", cpu_pending, 0);
    cpu_pending = 1'b0; cpu_req = 1'b0;
    chk("clr_done_count", done_cnt, 1);
    chk("clr_write_count", clr_next, NPIX);
    chk("ack_after_done", int'(last_ack_cyc > last_done_cyc), 1);
    repeat (20) tick(1'b0);
    chk("clr_done_once", done_cnt, 1);
    chk("clr_no_extra_writes", clr_next, NPIX);
    cnt = 0;
    for (int i = 0; i < NPIX; i++) if (ram[i] !== 1'b0) cnt++;
    chk("ram_cleared", cnt, 0);
    clr_mon = 1'b0;

    // Table of CPU transactions with VGA slots interleaved.
    for (int t = 0; t < 13; t++) begin
      cpu_issue(tbl[t].we, tbl[t].addr, tbl[t].wdata);
      cpu_exp = XOR_MODE ? tbl[t].exp_xor : tbl[t].exp_plain;
      for (int k = 0; k < 20 && cpu_pending; k++) tick(1'b1);
      chk("tbl_ack_seen", cpu_pending, 0);
      cpu_pending = 1'b0; cpu_req = 1'b0;
      tick(1'b1);
    end

    // Checkerboard scan-out with randomized CPU traffic.
    fill_req = 1'b1; fill_cb = 1'b1;
    tick(1'b0);
    fill_req = 1'b0;
    for (int i = 0; i < NPIX; i++) shadow[i] = cb_pix(i);
    act = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 32 == 0) act = ($urandom_range(0, 3) != 0);
      if (!cpu_pending && !cpu_ack && $urandom_range(0, 2) == 0)
        cpu_issue(1'($urandom_range(0, 1)), $urandom_range(0, 63), 1'($urandom_range(0, 1)));
      tick(act);
    end
    for (int k = 0; k < 20 && cpu_pending; k++) tick(1'b1);
    chk("rand_ack_seen", cpu_pending, 0);
    cpu_pending = 1'b0; cpu_req = 1'b0;
    tick(1'b0);
    cnt = 0;
    for (int i = 0; i < NPIX; i++) if (ram[i] !== shadow[i]) cnt++;
    chk("ram_vs_model", cnt, 0);

    // Reset in the middle of a clear, then restart from address 0.
    clr_mon = 1'b1; clr_next = 0; done_cnt = 0;
    clr_start = 1'b1;
    tick(1'b0);
    clr_start = 1'b0;
    for (int k = 0; k < 2000 && clr_next < 900; k++) tick(1'b0);
    #4;
    reset_n = 1'b0;
    #1;
    chk_reset("midclr");
    p1_valid = 1'b0; exp_pix = 1'b0;
    repeat (3) tick(1'b0);
    reset_n = 1'b1;
    repeat (3) tick(1'b0);
    chk("midclr_no_done", done_cnt, 0);
    clr_next = 0;
    clr_start = 1'b1;
    tick(1'b0);
    clr_start = 1'b0;
    for (int k = 0; k < 5000 && done_cnt == 0; k++) tick(1'b0);
    chk("restart_done_count", done_cnt, 1);
    chk("restart_write_count", clr_next, NPIX);
    clr_mon = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/chip8_fb_arbiter.md
Name: chip8_fb_arbiter

Overview:
- Arbitrates the single-port 2048x1 Chip8 framebuffer RAM between three users:
  - the VGA scan-out reader, which fetches 1 pixel per 25 MHz pixel clock;
  - the CPU draw/read port, which uses a req/ack handshake;
  - an internal clear-screen sequencer (CLS instruction).
- Sits between the CPU core, the framebuffer RAM and the VGA emulator.
- VGA always wins its slot; the CPU and the clear sequencer share the remaining cycles.

Parameters:
- ADDR_W, 11, framebuffer address width (64x32 = 2048 pixels).
- FB_LAST, 11'd2047, last address swept by the clear sequencer.
- CLEAR_VAL, 1'b0, pixel value written by the clear sequencer.

Ports:
- clk50  input  1  50 MHz system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- vga_addr  input  ADDR_W  pixel address requested by scan-out.
- vga_phase  input  1  equals hcount[0]; 0 marks the VGA slot.
- vga_active  input  1  high while the beam is inside the Chip8 window.
- vga_pixel  output  1  registered pixel returned to scan-out.
- cpu_req  input  1  CPU access request; held high until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  input  ADDR_W  CPU pixel address.
- cpu_wdata  input  1  CPU write data.
- cpu_ack  output  1  1-cycle completion pulse.
- cpu_rdata  output  1  read data; valid when cpu_ack is high.
- clr_start  input  1  pulse that starts a full-screen clear.
- clr_busy  output  1  high while a clear is in progress.
- clr_done  output  1  1-cycle pulse after the last clear write.
- mem_addr  output  ADDR_W  RAM address (combinational).
- mem_we  output  1  RAM write enable (combinational).
- mem_wdata  output  1  RAM write data.
- mem_rdata  input  1  RAM read data; 1-cycle latency.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - vga_pixel=0, cpu_ack=0, cpu_rdata=0, clr_busy=0, clr_done=0, clear counter=0, FSM=IDLE.
  - A reset during a clear abandons it; no clr_done pulse is produced.
- VGA slot (vga_active=1 and vga_phase=0):
  - mem_addr=vga_addr, mem_we=0.
  - Next cycle: vga_pixel <= mem_rdata. vga_pixel holds until the next VGA slot.
  - When vga_active=0, vga_pixel <= 0.
- Free slot: every cycle that is not a VGA slot. Free slots are granted in this priority order:
  1. Clear sequencer, if clr_busy.
  2. CPU, if cpu_req=1 and no CPU access is pending.
  3. Otherwise idle: mem_we=0 and mem_addr=0.
- FSM states:
  - IDLE:
    - clr_start=1 -> CLEAR, counter=0, clr_busy=1.
    - CPU grant in a free slot -> CPU_ACK.
    - If clr_start and a CPU grant occur in the same cycle, the clear wins; the CPU waits.
  - CPU_ACK (1 cycle):
    - cpu_ack=1.
    - For a read: cpu_rdata=mem_rdata. For a write: cpu_rdata=0.
    - Returns to IDLE.
    - No grant is issued in this cycle, so there is at most 1 CPU access per 2 cycles.
  - CLEAR:
    - Each free slot: mem_addr=counter, mem_we=1, mem_wdata=CLEAR_VAL, counter+1.
    - VGA slots stall the counter.
    - After the write at FB_LAST: clr_busy=0 and clr_done=1 for 1 cycle, then -> IDLE.
    - The counter does not wrap.
- clr_start while busy is ignored.
- cpu_req raised during a clear is stalled until the clear has finished, then granted in the first free slot.
- Worst-case CPU latency outside a clear is 3 cycles from req to ack:
  - wait for a VGA slot,
  - grant,
  - ack.
- A full clear takes 2048 free slots: about 4096 cycles during active video, 2048 cycles in blanking.
- All outputs except the mem_* signals are registered.

Optional Feature:
- Macro: CHIP8_FB_XOR_EN.
- Defined:
  - A CPU write becomes a DRW-style XOR read-modify-write.
  - First free slot: read cpu_addr.
  - Next free slot: write old^cpu_wdata.
  - cpu_ack is issued in the cycle after the write.
  - cpu_rdata = old & cpu_wdata, the collision flag for VF.
  - Adds states CPU_RMW_RD and CPU_RMW_WR. VGA slots may fall between them, and the held old value must survive them.
- Undefined:
  - Writes are plain single-slot writes; cpu_rdata=0 on writes.

Test Plan:
- Reset mid-clear (counter about 900) -> all outputs 0 immediately; no clr_done; the next clr_start restarts from address 0.
- VGA scan with vga_active=1, RAM preloaded in a checkerboard -> vga_pixel matches RAM[vga_addr] one cycle after each phase-0 slot; mem_we is never 1 in a VGA slot.
- CPU write addr 11'd100=1, then read 100 -> ack within 3 cycles of each req; read cpu_rdata=1; address 99 is unchanged.
- clr_start during blanking -> exactly 2048 consecutive writes of 0 to addresses 0..2047; clr_done pulses once; clr_busy is low on the clr_done cycle.
- cpu_req and clr_start in the same cycle -> the CPU ack arrives only after clr_done; a second clr_start while busy has no effect.
- XOR_EN: write 1 to address 5 twice -> first ack has rdata=0 and RAM[5]=1; second ack has rdata=1 and RAM[5]=0; run with VGA slots interleaved.
